// File: rtl/conv2_pool_stage.sv
// conv2_pool_stage: 2x2/stride-2 max-pool over the conv-2 result buffer, one window at a time.
// Define CONV2_POOL_RELU_EN to clamp negative pooled values to zero before the write.
module conv2_pool_stage #(
  parameter int DATA_WIDTH         = 32,
  parameter int FRACTION_WIDTH     = 16,
  parameter int ADDR_WIDTH         = 16,
  parameter int CONV_RESULT_WIDTH  = 24,
  parameter int CONV_RESULT_HEIGHT = 24,
  parameter int CHANNEL_NUM        = 2,
  parameter int RD_LATENCY         = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] channel_count,
  output logic                  busy,
  output logic                  done
);
  localparam int PW    = CONV_RESULT_WIDTH / 2;
  localparam int PH    = CONV_RESULT_HEIGHT / 2;
  localparam int PLANE = CONV_RESULT_WIDTH * CONV_RESULT_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] PC_LAST = ADDR_WIDTH'(PW - 1);
  localparam logic [ADDR_WIDTH-1:0] PR_LAST = ADDR_WIDTH'(PH - 1);
  localparam logic [ADDR_WIDTH-1:0] CH_LAST = ADDR_WIDTH'(CHANNEL_NUM - 1);

  if (FRACTION_WIDTH >= DATA_WIDTH || RD_LATENCY < 1) begin : g_bad_cfg
    $error("conv2_pool_stage: FRACTION_WIDTH must be < DATA_WIDTH and RD_LATENCY >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                       state, state_nxt;
  logic [ADDR_WIDTH-1:0]        ch, pr, pc;
  logic [ADDR_WIDTH-1:0]        ch_n, pr_n, pc_n;
  logic [ADDR_WIDTH-1:0]        out_idx;
  logic [1:0]                   fidx, cap_cnt;
  logic [RD_LATENCY-1:0]        vld_pipe;
  logic signed [DATA_WIDTH-1:0] max_q, max_nxt;
  logic                         issue, cap, last_cap, last_win;

  // Buffer word address of sample k (k[1] = row offset, k[0] = column offset) of window (c,r,p).
  function automatic logic [ADDR_WIDTH-1:0] rd_index(input logic [ADDR_WIDTH-1:0] c,
                                                     input logic [ADDR_WIDTH-1:0] r,
                                                     input logic [ADDR_WIDTH-1:0] p,
                                                     input logic [1:0]            k);
    return ADDR_WIDTH'(32'(c) * 32'(PLANE)
                     + (32'(r) * 32'd2 + 32'(k[1])) * 32'(CONV_RESULT_WIDTH)
                     + 32'(p) * 32'd2 + 32'(k[0]));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] activate(input logic signed [DATA_WIDTH-1:0] v);
`ifdef CONV2_POOL_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign issue         = (state == S_FETCH);
  assign cap           = vld_pipe[RD_LATENCY-1];
  assign last_cap      = cap && (cap_cnt == 2'd3);
  assign last_win      = (ch == CH_LAST) && (pr == PR_LAST) && (pc == PC_LAST);
  assign channel_count = ch;

  // First sample of a window always loads; max is never seeded with zero.
  assign max_nxt = ((cap_cnt == 2'd0) || ($signed(rd_data) > max_q)) ? $signed(rd_data) : max_q;

  always_comb begin
    pc_n = pc + 1'b1;
    pr_n = pr;
    ch_n = ch;
    if (pc == PC_LAST) begin
      pc_n = '0;
      pr_n = pr + 1'b1;
      if (pr == PR_LAST) begin
        pr_n = '0;
        ch_n = ch + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = S_FETCH;
      S_FETCH: if (fidx == 2'd3) state_nxt = S_DRAIN;
      S_DRAIN: if (last_cap) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_win ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      ch       <= '0;
      pr       <= '0;
      pc       <= '0;
      out_idx  <= '0;
      fidx     <= '0;
      cap_cnt  <= '0;
      vld_pipe <= '0;
      max_q    <= '0;
      rd_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_en  <= 1'b0;
      done   <= 1'b0;

      // Capture timing follows the issued-address tags, independent of FSM state.
      vld_pipe[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (cap) begin
        max_q   <= max_nxt;
        cap_cnt <= cap_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (run) begin
            busy    <= 1'b1;
            ch      <= '0;
            pr      <= '0;
            pc      <= '0;
            out_idx <= '0;
            fidx    <= '0;
            cap_cnt <= '0;
            rd_addr <= rd_index('0, '0, '0, 2'd0);
          end
        end
        S_FETCH: begin
          fidx <= fidx + 1'b1;
          if (fidx != 2'd3) rd_addr <= rd_index(ch, pr, pc, fidx + 2'd1);
        end
        S_DRAIN: begin
          if (last_cap) begin
            wr_en   <= 1'b1;
            wr_addr <= out_idx;
            wr_data <= activate(max_nxt);
          end
        end
        S_WRITE: begin
          out_idx <= out_idx + 1'b1;
          if (last_win) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            ch      <= ch_n;
            pr      <= pr_n;
            pc      <= pc_n;
            rd_addr <= rd_index(ch_n, pr_n, pc_n, 2'd0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv2_pool_stage.sv
// Bench for conv2_pool_stage: four builds (4x4/2ch/L2, 4x4/1ch/L1, 5x5/1ch/L3, 4x4/1ch/L2)
// checked every cycle against a window-max model, plus hand-computed literal results.
module tb_conv2_pool_stage;
  localparam int NI = 4;

  function automatic int wof(input int g);  return (g == 2) ? 5 : 4; endfunction
  function automatic int chof(input int g); return (g == 0) ? 2 : 1; endfunction
  function automatic int lof(input int g);  return (g == 1) ? 1 : (g == 2) ? 3 : 2; endfunction

`ifdef CONV2_POOL_RELU_EN
  localparam logic [31:0] EXP_NEG = 32'h0000_0000;
  localparam logic [31:0] EXP_M3  = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_NEG = 32'hFFFF_FFFE;
  localparam logic [31:0] EXP_M3  = 32'hFFFF_FFFD;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        run_v     [NI];
  logic        rst_v     [NI];
  logic [15:0] rd_addr_v [NI];
  logic [31:0] rd_data_v [NI];
  logic        wr_en_v   [NI];
  logic [15:0] wr_addr_v [NI];
  logic [31:0] wr_data_v [NI];
  logic [15:0] chan_v    [NI];
  logic        busy_v    [NI];
  logic        done_v    [NI];

  logic [31:0] mem  [NI][64];
  logic [31:0] wlog [NI][16];
  int          cyc  [NI];
  int          wcnt [NI];
  bit          act  [NI];
  logic        busy_p [NI];
  int          chk = 0;
  int          err = 0;

  for (genvar g = 0; g < NI; g++) begin : u
    localparam int L = lof(g);
    logic [31:0] q [L];
    conv2_pool_stage #(
      .DATA_WIDTH(32), .FRACTION_WIDTH(16), .ADDR_WIDTH(16),
      .CONV_RESULT_WIDTH(wof(g)), .CONV_RESULT_HEIGHT(wof(g)),
      .CHANNEL_NUM(chof(g)), .RD_LATENCY(L)
    ) dut (
      .clk(clk), .reset(rst_v[g]), .run(run_v[g]),
      .rd_addr(rd_addr_v[g]), .rd_data(rd_data_v[g]),
      .wr_en(wr_en_v[g]), .wr_addr(wr_addr_v[g]), .wr_data(wr_data_v[g]),
      .channel_count(chan_v[g]), .busy(busy_v[g]), .done(done_v[g])
    );
    // Synchronous RAM with RD_LATENCY cycles of registered read.
    always @(posedge clk) begin
      q[0] <= mem[g][rd_addr_v[g][5:0]];
      for (int k = 1; k < L; k++) q[k] <= q[k-1];
    end
    assign rd_data_v[g] = q[L-1];
  end

  task automatic check(input int i, input string nm, input logic [31:0] got, input logic [31:0] want);
    chk++;
    if (got !== want) begin
      err++;
      $display("FAIL u%0d %s got %h want %h (t=%0t)", i, nm, got, want, $time);
    end
  endtask

  // Pooled output k of instance i: max over its 2x2 window, then optional ReLU.
  function automatic logic [31:0] model(input int i, input int k);
    int w = wof(i);
    int pw = w / 2;
    int c = k / (pw * pw);
    int r = (k % (pw * pw)) / pw;
    int p = k % pw;
    logic signed [31:0] m, s;
    m = mem[i][c*w*w + 2*r*w + 2*p];
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        s = mem[i][c*w*w + (2*r+dy)*w + 2*p + dx];
        if (s > m) m = s;
      end
`ifdef CONV2_POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  // Per-cycle comparison of every instance against the model.
  task automatic monitor();
    for (int i = 0; i < NI; i++) begin
      int w = wof(i);
      int pw = w / 2;
      int per = lof(i) + 5;
      int nw = chof(i) * pw * pw;
      int a, h, r, c;
      logic ew;
      if (!rst_v[i]) act[i] = 0;
      else if (run_v[i] && !busy_p[i]) begin act[i] = 1; cyc[i] = 0; wcnt[i] = 0; end
      else if (act[i]) cyc[i]++;
      if (act[i]) begin
        ew = ((cyc[i] + 1) % per == 0) && (cyc[i] + 1 <= nw * per);
        check(i, "wr_en", {31'd0, wr_en_v[i]}, {31'd0, ew});
        if (wr_en_v[i] === 1'b1) begin
          check(i, "wr_addr", {16'd0, wr_addr_v[i]}, wcnt[i]);
          check(i, "wr_data", wr_data_v[i], model(i, wcnt[i]));
          check(i, "channel_count", {16'd0, chan_v[i]}, wcnt[i] / (pw * pw));
          wlog[i][wcnt[i] % 16] = wr_data_v[i];
          wcnt[i]++;
        end
        check(i, "busy", {31'd0, busy_v[i]}, (cyc[i] < nw * per) ? 1 : 0);
        check(i, "done", {31'd0, done_v[i]}, (cyc[i] == nw * per) ? 1 : 0);
        a = rd_addr_v[i];
        h = a / (w * w);
        r = (a % (w * w)) / w;
        c = a % w;
        check(i, "rd_addr_in_grid", (h < chof(i) && r < 2*pw && c < 2*pw) ? 1 : 0, 1);
        if (cyc[i] == nw * per) act[i] = 0;
      end
      busy_p[i] = busy_v[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic check_zero(input int i, input string nm);
    check(i, {nm, "_rd_addr"}, {16'd0, rd_addr_v[i]}, 0);
    check(i, {nm, "_wr_addr"}, {16'd0, wr_addr_v[i]}, 0);
    check(i, {nm, "_wr_data"}, wr_data_v[i], 0);
    check(i, {nm, "_chan"}, {16'd0, chan_v[i]}, 0);
    check(i, {nm, "_wr_en"}, {31'd0, wr_en_v[i]}, 0);
    check(i, {nm, "_busy"}, {31'd0, busy_v[i]}, 0);
    check(i, {nm, "_done"}, {31'd0, done_v[i]}, 0);
  endtask

  task automatic run_job(input int i, input int exp_done);
    int n;
    run_v[i] = 1'b1;
    tick();
    run_v[i] = 1'b0;
    n = 1;
    while (done_v[i] !== 1'b1 && n < 2000) begin tick(); n++; end
    check(i, "done_cycle", n, exp_done);
    tick();
    check(i, "done_one_cycle", {31'd0, done_v[i]}, 0);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < NI; i++) begin
      run_v[i] = 1'b0; rst_v[i] = 1'b0; act[i] = 0; busy_p[i] = 1'b0;
      wcnt[i] = 0; cyc[i] = 0;
      for (int k = 0; k < 64; k++) mem[i][k] = 32'd0;
      for (int k = 0; k < 16; k++) wlog[i][k] = 32'd0;
    end
    for (int k = 0; k < 16; k++) begin mem[1][k] = k; mem[3][k] = k; end
    for (int k = 0; k < 25; k++) mem[2][k] = k;
    for (int k = 0; k < 16; k++) mem[0][k] = 32'((k * 7) % 13 - 6);
    mem[0][0] = -32'sd5; mem[0][1] = -32'sd2; mem[0][4] = -32'sd9; mem[0][5] = -32'sd7;
    for (int k = 16; k < 32; k++) mem[0][k] = 32'hFFFF_FFFD;

    repeat (3) tick();
    for (int i = 0; i < NI; i++) check_zero(i, "reset");
    for (int i = 0; i < NI; i++) rst_v[i] = 1'b1;
    tick();

    // Index-valued 4x4 buffer, latency 2.
    run_job(3, 29);
    check(3, "t1_count", wcnt[3], 4);
    check(3, "t1_w0", wlog[3][0], 32'd5);
    check(3, "t1_w1", wlog[3][1], 32'd7);
    check(3, "t1_w2", wlog[3][2], 32'd13);
    check(3, "t1_w3", wlog[3][3], 32'd15);

    // Same data at latency 1 and 3 (the latter on a 5x5 grid).
    run_job(1, 25);
    check(1, "l1_w0", wlog[1][0], 32'd5);
    check(1, "l1_w3", wlog[1][3], 32'd15);
    run_job(2, 33);
    check(2, "odd_count", wcnt[2], 4);
    check(2, "odd_w0", wlog[2][0], 32'd6);
    check(2, "odd_w1", wlog[2][1], 32'd8);
    check(2, "odd_w2", wlog[2][2], 32'd16);
    check(2, "odd_w3", wlog[2][3], 32'd18);

    // Run re-pulsed while busy, then reset inside the third window.
    run_v[0] = 1'b1; tick(); run_v[0] = 1'b0;
    repeat (4) tick();
    run_v[0] = 1'b1; tick(); run_v[0] = 1'b0;
    repeat (10) tick();
    rst_v[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); check_zero(0, "abort"); end
    rst_v[0] = 1'b1;
    pulses = 0;
    repeat (12) begin
      tick();
      if (wr_en_v[0] === 1'b1 || done_v[0] === 1'b1) pulses++;
    end
    check(0, "abort_no_pulses", pulses, 0);
    check(0, "abort_writes_before", wcnt[0], 2);

    run_job(0, 57);
    check(0, "ch2_count", wcnt[0], 8);
    check(0, "neg_window", wlog[0][0], EXP_NEG);
    for (int k = 4; k < 8; k++) check(0, "ch1_value", wlog[0][k], EXP_M3);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
